// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: op encodings, RS tags, mul/div FSM states and the
// datapath widths that the reservation stations and CDB arbiter agree on.
package tomasulo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_TAG_W  = 3;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  localparam logic [DEF_TAG_W-1:0] TAG_MUL1 = 3'b100;
  localparam logic [DEF_TAG_W-1:0] TAG_MUL2 = 3'b101;
  localparam logic [DEF_TAG_W-1:0] TAG_MUL3 = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC_MUL,
    ST_EXEC_DIV,
    ST_WAIT_CDB
  } muldiv_state_e;

endpackage

// File: rtl/unidade_mul_div_cdb_if.sv
// Issue bundle from the mul/div reservation stations plus the CDB req/grant pair.
// divZero exists only when MULDIV_DIVZERO_FLAG_EN is defined.
interface unidade_mul_div_cdb_if
  import tomasulo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W
);
  logic              dadoPronto;
  logic              operation;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;
  logic [TAG_W-1:0]  nameForCDB;
  logic              cdbGrant;
  logic              cdbReq;
  logic [TAG_W-1:0]  cdbName;
  logic [DATA_W-1:0] cdbData;
  logic              unitBusy;
  logic              iqOverflow;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic              divZero;
`endif

  modport master (
    output dadoPronto, operation, out0, out1, nameForCDB, cdbGrant,
`ifdef MULDIV_DIVZERO_FLAG_EN
    input  divZero,
`endif
    input  cdbReq, cdbName, cdbData, unitBusy, iqOverflow
  );

  modport slave (
    input  dadoPronto, operation, out0, out1, nameForCDB, cdbGrant,
`ifdef MULDIV_DIVZERO_FLAG_EN
    output divZero,
`endif
    output cdbReq, cdbName, cdbData, unitBusy, iqOverflow
  );
endinterface

// File: rtl/unidade_mul_div_cdb_divisor_serial.sv
// Unsigned restoring divider, one quotient bit per clock, DATA_W steps after start.
// done is high during the cycle whose closing edge performs the final step.
module divisor_serial #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] quotient
);
  localparam int STEP_W = $clog2(DATA_W + 1);

  logic [STEP_W-1:0] steps;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   diff;
  logic              ge;

  assign rem_sh = {rem, quo[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  // A zero divisor always "fits", which yields the all-ones quotient.
  assign ge     = (dvs == '0) || !diff[DATA_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      steps <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
    end else if (start) begin
      steps <= STEP_W'(DATA_W);
      rem   <= '0;
      quo   <= a;
      dvs   <= b;
    end else if (steps != '0) begin
      steps <= steps - STEP_W'(1);
      rem   <= ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
      quo   <= {quo[DATA_W-2:0], ge};
    end
  end

  assign done     = (steps == STEP_W'(1));
  assign quotient = quo;
endmodule

// File: rtl/unidade_mul_div_cdb.sv
// Mul/div functional unit: issue queue, single in-flight op, CDB req/grant output.
// Optional divide-by-zero flag output under MULDIV_DIVZERO_FLAG_EN.
//   state       | meaning
//   ST_IDLE     | waiting for a queued op; pops the head when one exists
//   ST_EXEC_MUL | product already captured, counting out the MUL latency
//   ST_EXEC_DIV | serial divider running
//   ST_WAIT_CDB | result held on cdbName/cdbData until granted
module unidade_mul_div_cdb
  import tomasulo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TAG_W    = DEF_TAG_W,
  parameter int IQ_DEPTH = 4,
  parameter int MUL_LAT  = 3
) (
  input logic                  clock,
  input logic                  reset,
  unidade_mul_div_cdb_if.slave bus
);
  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef struct packed {
    op_e               op;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } iq_entry_t;

  iq_entry_t         iq_mem [IQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    iq_count;
  logic              iq_full;
  logic              iq_overflow;
  logic              push;
  logic              pop;
  iq_entry_t         head;

  muldiv_state_e     state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  op_e               op_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] prod_q;
  logic [DATA_W-1:0] mul_lo;
  logic              div_done;
  logic [DATA_W-1:0] div_quotient;

  assign head    = iq_mem[rd_ptr];
  assign iq_full = (iq_count == (PTR_W+1)'(IQ_DEPTH));
  assign push    = bus.dadoPronto && (!iq_full || pop);
  assign mul_lo  = head.a * head.b;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      iq_count    <= '0;
      iq_overflow <= 1'b0;
    end else begin
      if (push) begin
        iq_mem[wr_ptr] <= '{op: op_e'(bus.operation), tag: bus.nameForCDB,
                            a: bus.out0, b: bus.out1};
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      iq_count <= iq_count + (PTR_W+1)'(1);
      else if (pop && !push) iq_count <= iq_count - (PTR_W+1)'(1);
      if (bus.dadoPronto && !push) iq_overflow <= 1'b1;
    end
  end

  divisor_serial #(.DATA_W(DATA_W)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (pop && (head.op == OP_DIV)),
    .a        (head.a),
    .b        (head.b),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_q   <= OP_MUL;
      tag_q  <= '0;
      prod_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (pop) begin
        op_q   <= head.op;
        tag_q  <= head.tag;
        prod_q <= mul_lo;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (iq_count != '0) begin
          pop = 1'b1;
          if (head.op == OP_DIV) begin
            state_nx = ST_EXEC_DIV;
          end else if (MUL_LAT == 1) begin
            state_nx = ST_WAIT_CDB;
          end else begin
            state_nx = ST_EXEC_MUL;
            cnt_nx   = CNT_W'(MUL_LAT - 1);
          end
        end
      end
      ST_EXEC_MUL: begin
        if (cnt <= CNT_W'(1)) state_nx = ST_WAIT_CDB;
        else                  cnt_nx   = cnt - CNT_W'(1);
      end
      ST_EXEC_DIV: begin
        if (div_done) state_nx = ST_WAIT_CDB;
      end
      ST_WAIT_CDB: begin
        if (bus.cdbGrant) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs read zero whenever no result is pending.
  assign bus.cdbReq     = (state == ST_WAIT_CDB);
  assign bus.cdbName    = bus.cdbReq ? tag_q : '0;
  assign bus.cdbData    = !bus.cdbReq ? '0 : (op_q == OP_DIV) ? div_quotient : prod_q;
  assign bus.unitBusy   = (iq_count != '0) || (state != ST_IDLE);
  assign bus.iqOverflow = iq_overflow;

`ifdef MULDIV_DIVZERO_FLAG_EN
  logic divz_q;

  always_ff @(posedge clock) begin
    if (reset)    divz_q <= 1'b0;
    else if (pop) divz_q <= (head.op == OP_DIV) && (head.b == '0);
  end

  assign bus.divZero = bus.cdbReq && divz_q;
`endif
endmodule

// File: tb/tb_unidade_mul_div_cdb.sv
// Self-checking bench for unidade_mul_div_cdb: directed vector table, multi-cycle
// corner sequences, and randomized traffic against an order-preserving result model.
module tb_unidade_mul_div_cdb;
  localparam int DATA_W   = 16;
  localparam int TAG_W    = 3;
  localparam int IQ_DEPTH = 4;
  localparam int MUL_LAT  = 3;
  localparam int DIV_LAT  = DATA_W + 1;
  localparam int NRAND    = 60;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  unidade_mul_div_cdb_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  unidade_mul_div_cdb #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .IQ_DEPTH(IQ_DEPTH), .MUL_LAT(MUL_LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  tag;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [2:0]  tag;
    logic [15:0] data;
    logic        dz;
  } exp_t;

  vec_t vecs[6];
  exp_t exp_q[$];

  function automatic exp_t model(input logic op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] tag);
    exp_t e;
    int unsigned prod;
    e.tag = tag;
    e.dz  = op && (b == 16'd0);
    if (!op) begin
      prod   = int'(a) * int'(b);
      e.data = prod[15:0];
    end else if (b == 16'd0) begin
      e.data = 16'hFFFF;
    end else begin
      e.data = a / b;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_issue(input logic op, input logic [15:0] a, input logic [15:0] b,
                             input logic [2:0] tag);
    bus.dadoPronto = 1'b1;
    bus.operation  = op;
    bus.out0       = a;
    bus.out1       = b;
    bus.nameForCDB = tag;
  endtask

  task automatic issue(input logic op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] tag);
    drive_issue(op, a, b, tag);
    @(negedge clock);
    bus.dadoPronto = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (bus.cdbReq !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int   n;
    int   hits;
    int   issued;
    int   cyc;
    logic g;
    exp_t e;

    tests = 0;
    fails = 0;
    bus.dadoPronto = 1'b0;
    bus.operation  = 1'b0;
    bus.out0       = '0;
    bus.out1       = '0;
    bus.nameForCDB = '0;
    bus.cdbGrant   = 1'b0;
    reset          = 1'b1;
    @(negedge clock);
    do_reset();

    chk("rst_req",  32'(bus.cdbReq), 0);
    chk("rst_name", 32'(bus.cdbName), 0);
    chk("rst_data", 32'(bus.cdbData), 0);
    chk("rst_busy", 32'(bus.unitBusy), 0);
    chk("rst_ovf",  32'(bus.iqOverflow), 0);

    vecs[0] = '{1'b0, 16'd7,    16'd9,    3'b100, 16'h003F};
    vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 3'b101, 16'h0001};
    vecs[2] = '{1'b1, 16'd100,  16'd7,    3'b101, 16'h000E};
    vecs[3] = '{1'b1, 16'h1234, 16'h0000, 3'b110, 16'hFFFF};
    vecs[4] = '{1'b1, 16'hFFFF, 16'h0001, 3'b100, 16'hFFFF};
    vecs[5] = '{1'b0, 16'h1234, 16'h0010, 3'b110, 16'h2340};

    bus.cdbGrant = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_req(n);
      chk($sformatf("vec%0d_lat", i), 32'(n), vecs[i].op ? DIV_LAT : MUL_LAT);
      chk($sformatf("vec%0d_name", i), 32'(bus.cdbName), 32'(vecs[i].tag));
      chk($sformatf("vec%0d_data", i), 32'(bus.cdbData), 32'(vecs[i].exp));
`ifdef MULDIV_DIVZERO_FLAG_EN
      chk($sformatf("vec%0d_dz", i), 32'(bus.divZero),
          32'(vecs[i].op && (vecs[i].b == 16'd0)));
`endif
      @(negedge clock);
      chk($sformatf("vec%0d_req_drop", i), 32'(bus.cdbReq), 0);
`ifdef MULDIV_DIVZERO_FLAG_EN
      chk($sformatf("vec%0d_dz_drop", i), 32'(bus.divZero), 0);
`endif
    end

    // Grant held off: result must sit unchanged until granted.
    bus.cdbGrant = 1'b0;
    issue(1'b1, 16'd100, 16'd7, 3'b101);
    wait_req(n);
    chk("hold_lat", 32'(n), DIV_LAT);
    for (int k = 0; k < 5; k++) begin
      chk("hold_req",  32'(bus.cdbReq), 1);
      chk("hold_data", 32'(bus.cdbData), 32'h000E);
      chk("hold_name", 32'(bus.cdbName), 32'(3'b101));
      @(negedge clock);
    end
    bus.cdbGrant = 1'b1;
    chk("hold_last", 32'(bus.cdbData), 32'h000E);
    @(negedge clock);
    chk("hold_release", 32'(bus.cdbReq), 0);

    // Overflow: park one result in WAIT_CDB, then five back-to-back issues.
    bus.cdbGrant = 1'b0;
    exp_q.delete();
    issue(1'b0, 16'd3, 16'd5, 3'b100);
    exp_q.push_back(model(1'b0, 16'd3, 16'd5, 3'b100));
    wait_req(n);
    chk("ovf_pre_lat", 32'(n), MUL_LAT);
    for (int j = 0; j < 5; j++) begin
      logic        op;
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  t;
      op = j[0];
      a  = 16'(1000 + 37 * j);
      b  = 16'(3 + j);
      t  = 3'(4 + (j % 3));
      drive_issue(op, a, b, t);
      if (j < 4) exp_q.push_back(model(op, a, b, t));
      @(negedge clock);
    end
    bus.dadoPronto = 1'b0;
    chk("ovf_flag", 32'(bus.iqOverflow), 1);
    chk("ovf_busy", 32'(bus.unitBusy), 1);
    bus.cdbGrant = 1'b1;
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      if (bus.cdbReq) begin
        e = exp_q.pop_front();
        chk("ovf_name", 32'(bus.cdbName), 32'(e.tag));
        chk("ovf_data", 32'(bus.cdbData), 32'(e.data));
      end
      @(negedge clock);
    end
    chk("ovf_drained", 32'(exp_q.size()), 0);
    hits = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.cdbReq) hits++;
      @(negedge clock);
    end
    chk("ovf_no_fifth", 32'(hits), 0);
    chk("ovf_idle", 32'(bus.unitBusy), 0);
    chk("ovf_sticky", 32'(bus.iqOverflow), 1);
    do_reset();
    chk("ovf_cleared", 32'(bus.iqOverflow), 0);

    // Reset during EXEC_DIV with two ops queued behind it.
    bus.cdbGrant = 1'b1;
    drive_issue(1'b1, 16'h8000, 16'd3, 3'b101);
    @(negedge clock);
    drive_issue(1'b0, 16'd11, 16'd12, 3'b100);
    @(negedge clock);
    drive_issue(1'b0, 16'd13, 16'd14, 3'b110);
    @(negedge clock);
    bus.dadoPronto = 1'b0;
    repeat (4) @(negedge clock);
    chk("rmid_busy_before", 32'(bus.unitBusy), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("rmid_req",  32'(bus.cdbReq), 0);
    chk("rmid_busy", 32'(bus.unitBusy), 0);
    reset = 1'b0;
    hits = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.cdbReq || bus.unitBusy) hits++;
      @(negedge clock);
    end
    chk("rmid_no_stale", 32'(hits), 0);

    // Random traffic with random grants; outstanding work kept within queue depth.
    exp_q.delete();
    issued = 0;
    cyc    = 0;
    while ((issued < NRAND || exp_q.size() > 0) && cyc < 8000) begin
      if (bus.cdbReq) begin
        if (exp_q.size() == 0) begin
          chk("rand_spurious", 1, 0);
        end else begin
          chk("rand_name", 32'(bus.cdbName), 32'(exp_q[0].tag));
          chk("rand_data", 32'(bus.cdbData), 32'(exp_q[0].data));
`ifdef MULDIV_DIVZERO_FLAG_EN
          chk("rand_dz", 32'(bus.divZero), 32'(exp_q[0].dz));
`endif
        end
      end
      g = ($urandom_range(0, 2) != 0);
      bus.cdbGrant = g;
      if (bus.cdbReq && g && exp_q.size() > 0) void'(exp_q.pop_front());
      if (issued < NRAND && exp_q.size() < IQ_DEPTH && $urandom_range(0, 1) == 1) begin
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  t;
        op = 1'($urandom_range(0, 1));
        a  = 16'($urandom);
        b  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(0, 16'hFFFF) >> $urandom_range(0, 15));
        t  = 3'($urandom_range(4, 6));
        drive_issue(op, a, b, t);
        exp_q.push_back(model(op, a, b, t));
        issued++;
      end else begin
        bus.dadoPronto = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    bus.dadoPronto = 1'b0;
    chk("rand_drained", 32'(exp_q.size()), 0);
    chk("rand_no_ovf", 32'(bus.iqOverflow), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
